// File: rtl/calc_pkg.sv
// Shared types and constants for the result-to-BCD display path.
package calc_pkg;

   localparam int IN_W        = 16;
   localparam int INT_DIGITS  = 5;
   localparam int OUT_DIGITS  = 3;
   localparam int CNT_W       = $clog2(IN_W);
   localparam int MAX_DISPLAY = 999;
   localparam logic [3:0] SAT_DIGIT = 4'd9;

   typedef logic [3:0] bcd_t;
   typedef bcd_t [INT_DIGITS-1:0] bcd_vec_t;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   // True when the converted value cannot be shown on three display digits.
   function automatic logic bcd_exceeds_display(bcd_vec_t d);
      logic [13:0] low_val;
      low_val = 14'(d[2]) * 14'd100 + 14'(d[1]) * 14'd10 + 14'(d[0]);
      return (d[4] != 4'd0) || (d[3] != 4'd0) || (low_val > 14'(MAX_DISPLAY));
   endfunction

endpackage

// File: rtl/result_bcd_converter_if.sv
// Start/result request and converted-digit response bundle for the BCD stage.
interface result_bcd_converter_if;
   import calc_pkg::*;

   logic             start;
   logic [IN_W-1:0]  result;
   logic             busy;
   logic             done;
   logic             neg;
   logic             overflow;
   bcd_t             bcd_hundreds;
   bcd_t             bcd_tens;
   bcd_t             bcd_ones;

   modport master (
      output start, result,
      input  busy, done, neg, overflow, bcd_hundreds, bcd_tens, bcd_ones
   );

   modport slave (
      input  start, result,
      output busy, done, neg, overflow, bcd_hundreds, bcd_tens, bcd_ones
   );

endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_add3_digit
   import calc_pkg::*;
(
   input  bcd_t din,
   output bcd_t dout
);

   assign dout = (din >= 4'd5) ? bcd_t'(din + 4'd3) : din;

endmodule

// File: rtl/result_bcd_converter.sv
// Iterative binary-to-BCD converter for the signed ALU result feeding the display.
// state | meaning
// IDLE  | waiting for start; captures sign and magnitude of result
// SHIFT | one add-3/shift iteration per clock, IN_W iterations
// DONE  | registers sign, saturation and digits, pulses done
module result_bcd_converter
   import calc_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   result_bcd_converter_if.slave  bus
);

   localparam int SH_W = INT_DIGITS * 4 + IN_W;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

   state_t                  state;
   logic [CNT_W-1:0]        bit_cnt;
   bcd_vec_t                digits;
   bcd_vec_t                digits_adj;
   bcd_vec_t                digits_next;
   logic [IN_W-1:0]         mag;
   logic [IN_W-1:0]         mag_next;
   logic [IN_W-1:0]         mag_in;
   logic [SH_W-1:0]         shift_vec;
   logic                    neg_cap;
   logic                    busy_r;
   logic                    done_r;
   logic                    neg_r;
   logic                    ovf_r;
   bcd_t [OUT_DIGITS-1:0]   dout_r;

   for (genvar gi = 0; gi < INT_DIGITS; gi++) begin : g_add3
      bcd_add3_digit u_add3 (
         .din  (digits[gi]),
         .dout (digits_adj[gi])
      );
   end

   assign shift_vec = {digits_adj, mag} << 1;
   assign {digits_next, mag_next} = shift_vec;

   // Unsigned magnitude: -32768 becomes 16'h8000 and is read as 32768.
   assign mag_in = bus.result[IN_W-1] ? (~bus.result + IN_W'(1)) : bus.result;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         digits  <= '0;
         mag     <= '0;
         neg_cap <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         neg_r   <= 1'b0;
         ovf_r   <= 1'b0;
         dout_r  <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  neg_cap <= bus.result[IN_W-1];
                  mag     <= mag_in;
                  digits  <= '0;
                  bit_cnt <= '0;
                  busy_r  <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               digits  <= digits_next;
               mag     <= mag_next;
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == CNT_LAST) begin
                  state <= DONE;
               end
            end
            DONE: begin
               done_r <= 1'b1;
               busy_r <= 1'b0;
               neg_r  <= neg_cap;
               if (bcd_exceeds_display(digits)) begin
                  ovf_r  <= 1'b1;
                  dout_r <= {OUT_DIGITS{SAT_DIGIT}};
               end else begin
                  ovf_r  <= 1'b0;
                  dout_r <= digits[OUT_DIGITS-1:0];
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy         = busy_r;
   assign bus.done         = done_r;
   assign bus.neg          = neg_r;
   assign bus.overflow     = ovf_r;
   assign bus.bcd_hundreds = dout_r[2];
   assign bus.bcd_tens     = dout_r[1];
   assign bus.bcd_ones     = dout_r[0];

endmodule
